// File: rtl/iob_fp_add_arbiter.sv
// iob_fp_add_arbiter: round-robin share of one pipelined FP adder among N_REQ requesters, results steered back by tag
// Ports: clk_i/arst_n_i clock and async active-low reset; en_i enables new grants;
//        req_valid_i/req_ready_o/req_op_a_i/req_op_b_i per-requester op handshake (operands packed k*DATA_W);
//        res_valid_o/res_data_o one-hot result pulse to the originator;
//        add_start_o/add_op_a_o/add_op_b_o/add_done_i/add_res_i adder interface;
//        busy_o op issued or in flight; err_o sticky done/tag mismatch.
module iob_fp_add_arbiter #(
    parameter int DATA_W  = 32,
    parameter int N_REQ   = 4,
    parameter int LATENCY = 5
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    en_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*DATA_W-1:0] req_op_a_i,
    input  logic [N_REQ*DATA_W-1:0] req_op_b_i,
    output logic [N_REQ-1:0]        res_valid_o,
    output logic [DATA_W-1:0]       res_data_o,
    output logic                    add_start_o,
    output logic [DATA_W-1:0]       add_op_a_o,
    output logic [DATA_W-1:0]       add_op_b_o,
    input  logic                    add_done_i,
    input  logic [DATA_W-1:0]       add_res_i,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int TAG_W = $clog2(N_REQ);
    logic [TAG_W-1:0]   ptr, gnt, iss_id;
    logic               found, xfer;
    logic [LATENCY-1:0] tag_v;
    logic [TAG_W-1:0]   tag_id [LATENCY];
    // descending scan so the requester closest after ptr is the last writer and wins
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_valid_i[(int'(ptr) + i) % N_REQ]) begin
                gnt   = TAG_W'((int'(ptr) + i) % N_REQ);
                found = 1'b1;
            end
        end
    end
    assign req_ready_o = (arst_n_i && en_i && found) ? (N_REQ'(1) << gnt) : '0;
    assign xfer        = |(req_valid_i & req_ready_o);
    assign res_valid_o = (add_done_i && tag_v[LATENCY-1]) ? (N_REQ'(1) << tag_id[LATENCY-1]) : '0;
    assign res_data_o  = |res_valid_o ? add_res_i : '0;
    assign busy_o      = add_start_o | (|tag_v);
    // tag[0] loads from the issue stage, so entry LATENCY-1 lines up with the adder's done
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr         <= TAG_W'(N_REQ - 1);
            iss_id      <= '0;
            add_start_o <= 1'b0;
            add_op_a_o  <= '0;
            add_op_b_o  <= '0;
            tag_v       <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
            err_o       <= 1'b0;
        end else begin
            add_start_o <= xfer;
            if (xfer) begin
                ptr        <= gnt;
                iss_id     <= gnt;
                add_op_a_o <= req_op_a_i[gnt*DATA_W +: DATA_W];
                add_op_b_o <= req_op_b_i[gnt*DATA_W +: DATA_W];
            end
            tag_v[0]  <= add_start_o;
            tag_id[0] <= iss_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (add_done_i != tag_v[LATENCY-1]) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_iob_fp_add_arbiter.sv
// tb_iob_fp_add_arbiter: randomized + directed scoreboard bench for iob_fp_add_arbiter with a pipelined adder model
module tb_iob_fp_add_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int L  = 5;
    logic            clk = 1'b0, arst_n = 1'b0, en = 1'b0, inject = 1'b0;
    logic [N-1:0]    req_valid = '0, req_ready, res_valid;
    logic [N*DW-1:0] op_a = '0, op_b = '0;
    logic [DW-1:0]   res_data, add_op_a, add_op_b, add_res;
    logic            add_start, add_done, busy, err;
    iob_fp_add_arbiter #(.DATA_W(DW), .N_REQ(N), .LATENCY(L)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .en_i(en),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_a_i(op_a), .req_op_b_i(op_b),
        .res_valid_o(res_valid), .res_data_o(res_data),
        .add_start_o(add_start), .add_op_a_o(add_op_a), .add_op_b_o(add_op_b),
        .add_done_i(add_done), .add_res_i(add_res),
        .busy_o(busy), .err_o(err)
    );
    always #5 clk = ~clk;
    // positive-normal float add, truncating alignment
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, t;
        logic [24:0] ma, mb, s, tm;
        ea = a[30:23]; eb = b[30:23];
        ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
        if (ea < eb) begin
            t = ea; ea = eb; eb = t;
            tm = ma; ma = mb; mb = tm;
        end
        mb = (ea - eb > 8'd24) ? 25'd0 : mb >> (ea - eb);
        s = ma + mb;
        if (s[24]) begin
            s = s >> 1;
            ea = ea + 8'd1;
        end
        return {1'b0, ea, s[22:0]};
    endfunction
    // adder model: fixed LATENCY from start to done, shares the reset
    logic [L-1:0] pv;
    logic [DW-1:0] pr [L];
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pv <= '0;
            for (int i = 0; i < L; i++) pr[i] <= '0;
        end else begin
            pv <= {pv[L-2:0], add_start};
            for (int i = L - 1; i > 0; i--) pr[i] <= pr[i-1];
            pr[0] <= fadd(add_op_a, add_op_b);
        end
    end
    assign add_done = pv[L-1] | inject;
    assign add_res  = pr[L-1];
    typedef struct {int id; logic [31:0] data; int due;} exp_t;
    exp_t q[$];
    int cnt = 0, compared = 0, mismatched = 0, last = N - 1;
    always @(posedge clk) cnt <= cnt + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cnt);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (arst_n) begin
            if (|res_valid) begin
                if (q.size() == 0) chk("unexpected_res", 64'(res_valid), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("res_id", 64'(res_valid), 64'(1) << e.id);
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("res_cycle", 64'(cnt), 64'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cnt) begin
                e = q.pop_front();
                chk("res_missing", 64'(res_valid), 64'(1) << e.id);
            end
        end
    end
    function automatic int pick(input logic [N-1:0] v, input logic e);
        if (!e) return -1;
        for (int i = 1; i <= N; i++)
            if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction
    function automatic logic [N*DW-1:0] rops();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
        return r;
    endfunction
    task automatic cyc(input logic [N-1:0] v, input logic e, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        int k;
        @(negedge clk);
        #1;
        req_valid = v; en = e; op_a = a; op_b = b;
        #1;
        k = pick(v, e);
        chk("ready", 64'(req_ready), (k >= 0) ? (64'(1) << k) : 64'd0);
        if (k >= 0) begin
            q.push_back('{k, fadd(a[k*DW +: DW], b[k*DW +: DW]), cnt + L + 1});
            last = k;
        end
    endtask
    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++) cyc('0, e, op_a, op_b);
    endtask
    initial begin
        logic [N*DW-1:0] da, db;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", {53'd0, req_ready, res_valid, add_start, busy, err}, 64'd0);
        chk("reset_ops", {add_op_a, add_op_b}, 64'd0);
        arst_n = 1'b1;
        da = '0; db = '0;
        da[0 +: DW] = 32'h3F800000; db[0 +: DW] = 32'h40000000;
        cyc(4'b0001, 1'b1, da, db);
        idle(L + 3, 1'b1);
        repeat (12) cyc(4'b1111, 1'b1, rops(), rops());
        idle(L + 3, 1'b1);
        cyc(4'b0100, 1'b1, rops(), rops());
        cyc(4'b0101, 1'b1, rops(), rops());
        cyc(4'b0101, 1'b1, rops(), rops());
        idle(L + 3, 1'b1);
        cyc(4'b0011, 1'b1, rops(), rops());
        cyc(4'b0011, 1'b1, rops(), rops());
        cyc(4'b0011, 1'b0, rops(), rops());
        chk("busy_inflight", 64'(busy), 64'd1);
        cyc(4'b0011, 1'b0, rops(), rops());
        idle(L + 3, 1'b0);
        chk("busy_drained", 64'(busy), 64'd0);
        @(negedge clk); #1 inject = 1'b1;
        @(negedge clk); #1 inject = 1'b0;
        #1 chk("err_set", 64'(err), 64'd1);
        idle(5, 1'b1);
        chk("err_held", 64'(err), 64'd1);
        repeat (3) cyc(4'b0111, 1'b1, rops(), rops());
        @(posedge clk);
        #2 arst_n = 1'b0;
        q.delete();
        #1;
        chk("rst_ctl", {53'd0, req_ready, res_valid, add_start, busy, err}, 64'd0);
        chk("rst_ops", {add_op_a, add_op_b}, 64'd0);
        req_valid = '0;
        @(negedge clk); #1 arst_n = 1'b1;
        last = N - 1;
        da = '0; db = '0;
        da[0 +: DW] = 32'h3FC00000; db[0 +: DW] = 32'h40200000;
        cyc(4'b0001, 1'b1, da, db);
        idle(L + 3, 1'b1);
        chk("err_after_rst", 64'(err), 64'd0);
        for (int i = 0; i < 300; i++) cyc(N'($urandom), $urandom_range(0, 7) != 0, rops(), rops());
        idle(L + 3, 1'b1);
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("err_final", 64'(err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
